// File: rtl/mmu_ctx_pkg.sv
// Shared encodings and width helpers for the context-tagged MMU.
package mmu_pkg;

   localparam logic REG_SEL_CTRL  = 1'b0;
   localparam logic REG_SEL_ENTRY = 1'b1;

   localparam int CTRL_INS = 3;
   localparam int CTRL_SUP = 2;
   localparam int CTRL_CLR = 1;
   localparam int ENT_W    = 2;
   localparam int ENT_V    = 1;

   // inv_mask bit positions: {si, sd, ui, ud}
   localparam int INV_SI = 3;
   localparam int INV_SD = 2;
   localparam int INV_UI = 1;
   localparam int INV_UD = 0;

   localparam logic FT_MISS = 1'b1;
   localparam logic FT_PROT = 1'b0;

   typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} inv_state_t;

   function automatic int mmu_vw(input int nmmu);
      return $clog2(nmmu);
   endfunction

   function automatic int mmu_cw(input int nctx);
      return $clog2(nctx);
   endfunction

   function automatic int mmu_ppw(input int pa, input int va, input int vw);
      return pa - va + vw;
   endfunction

endpackage

// File: rtl/mmu_ctx_inv_seq.sv
// Invalidate sweep sequencer: walks one {ctx, vpage} row per cycle and
// emits the table clear strobes for that row.
module mmu_inv_seq
   import mmu_pkg::*;
#(
   parameter int VW = 3,
   parameter int CW = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               inv_req,
   input  logic [3:0]         inv_mask,
   input  logic               inv_all_ctx,
   input  logic [CW-1:0]      ctx,
   output logic               inv_busy,
   output logic [CW+VW-1:0]   clr_row,
   output logic [3:0]         clr_mask
);

   localparam int RW = CW + VW;
   localparam logic [RW-1:0] ROW_ONE = RW'(1);

   inv_state_t      state;
   logic [3:0]      mask_q;
   logic            all_q;
   logic [RW-1:0]   row;
   logic            last_row;

   // A single-context sweep ends at the last vpage; an all-context sweep at the last row overall.
   assign last_row = all_q ? (&row) : (&row[VW-1:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         mask_q <= '0;
         all_q  <= 1'b0;
         row    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (inv_req) begin
                  state  <= SWEEP;
                  mask_q <= inv_mask;
                  all_q  <= inv_all_ctx;
                  row    <= {(inv_all_ctx ? {CW{1'b0}} : ctx), {VW{1'b0}}};
               end
            end
            SWEEP: begin
               row <= row + ROW_ONE;
               if (last_row) state <= IDLE;
            end
         endcase
      end
   end

   assign inv_busy = (state == SWEEP);
   assign clr_row  = row;
   assign clr_mask = inv_busy ? mask_q : 4'b0000;

endmodule

// File: rtl/mmu_ctx.sv
// Context-tagged page MMU: separate I/D tables per (ctx, supmode), combinational
// lookup, first-fault sticky capture and pointer-based table programming.
module mmu_ctx
   import mmu_pkg::*;
#(
   parameter int RV   = 16,
   parameter int VA   = RV,
   parameter int PA   = RV,
   parameter int NMMU = 8,
   parameter int NCTX = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      mmu_enable,
   input  logic                      supmode,
   input  logic [mmu_cw(NCTX)-1:0]   ctx,
   input  logic                      is_pc,
   input  logic                      is_read,
   input  logic                      is_write,
   input  logic [VA-1:RV/16]         pcv,
   input  logic [VA-1:RV/16]         addrv,
   output logic [PA-1:RV/16]         pcp,
   output logic [PA-1:RV/16]         addrp,
   output logic                      mmu_miss_fault,
   output logic                      mmu_prot_fault,
   input  logic                      mmu_fault,
   input  logic                      inv_req,
   input  logic [3:0]                inv_mask,
   input  logic                      inv_all_ctx,
   output logic                      inv_busy,
   input  logic                      reg_write,
   input  logic                      reg_sel,
   input  logic [RV-1:0]             reg_data,
   output logic [RV-1:0]             reg_read
);

   localparam int VW   = mmu_vw(NMMU);
   localparam int CW   = mmu_cw(NCTX);
   localparam int PPW  = mmu_ppw(PA, VA, VW);
   localparam int AL   = RV / 16;
   localparam int PAW  = PA - AL;
   localparam int IW   = CW + 1 + VW;
   localparam int NENT = 1 << IW;
   localparam logic [VW-1:0] VP_ONE = VW'(1);

   logic [NENT-1:0]  i_valid, d_valid, d_wr;
   logic [PPW-1:0]   i_ppage [NENT];
   logic [PPW-1:0]   d_ppage [NENT];

   logic [VW-1:0]    ptr_vp;
   logic [CW-1:0]    ptr_ctx;
   logic             ptr_ins, ptr_sup;

   logic             f_pend, f_ovf, f_ins, f_sup, f_type;
   logic [VW-1:0]    f_vpage;
   logic [CW-1:0]    f_ctx;

   logic [CW+VW-1:0] clr_row;
   logic [3:0]       clr_mask;
   logic [IW-1:0]    sidx, uidx, i_idx, d_idx, ptr_idx;
   logic [VW-1:0]    pc_vp, ad_vp;
   logic             i_miss, d_miss, d_prot, ent_we, ctrl_we;
   logic             unused_bits;

   mmu_inv_seq #(.VW(VW), .CW(CW)) u_inv_seq (
      .clk         (clk),
      .reset_n     (reset_n),
      .inv_req     (inv_req),
      .inv_mask    (inv_mask),
      .inv_all_ctx (inv_all_ctx),
      .ctx         (ctx),
      .inv_busy    (inv_busy),
      .clr_row     (clr_row),
      .clr_mask    (clr_mask)
   );

   assign pc_vp   = pcv[VA-1:VA-VW];
   assign ad_vp   = addrv[VA-1:VA-VW];
   assign i_idx   = {ctx, supmode, pc_vp};
   assign d_idx   = {ctx, supmode, ad_vp};
   assign ptr_idx = {ptr_ctx, ptr_sup, ptr_vp};
   assign sidx    = {clr_row[CW+VW-1:VW], 1'b1, clr_row[VW-1:0]};
   assign uidx    = {clr_row[CW+VW-1:VW], 1'b0, clr_row[VW-1:0]};

   assign pcp   = mmu_enable ? {i_ppage[i_idx], pcv[VA-VW-1:AL]}   : PAW'(pcv);
   assign addrp = mmu_enable ? {d_ppage[d_idx], addrv[VA-VW-1:AL]} : PAW'(addrv);

   assign i_miss = mmu_enable & is_pc & ~i_valid[i_idx];
   assign d_miss = mmu_enable & (is_read | is_write) & ~d_valid[d_idx];
   assign d_prot = mmu_enable & is_write & d_valid[d_idx] & ~d_wr[d_idx];

   assign mmu_miss_fault = (i_miss | d_miss) & ~inv_busy;
   assign mmu_prot_fault = d_prot & ~inv_busy;

   // A committed fault pre-empts any register write in the same cycle.
   assign ctrl_we = reg_write & (reg_sel == REG_SEL_CTRL) & ~mmu_fault;
   assign ent_we  = reg_write & (reg_sel == REG_SEL_ENTRY) & ~mmu_fault & ~inv_busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_valid <= '0;
         d_valid <= '0;
      end else begin
         if (clr_mask[INV_SI]) i_valid[sidx] <= 1'b0;
         if (clr_mask[INV_SD]) d_valid[sidx] <= 1'b0;
         if (clr_mask[INV_UI]) i_valid[uidx] <= 1'b0;
         if (clr_mask[INV_UD]) d_valid[uidx] <= 1'b0;
         if (ent_we) begin
            if (ptr_ins) i_valid[ptr_idx] <= reg_data[ENT_V];
            else         d_valid[ptr_idx] <= reg_data[ENT_V];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ent_we) begin
         if (ptr_ins) begin
            i_ppage[ptr_idx] <= reg_data[RV-1:RV-PPW];
         end else begin
            d_ppage[ptr_idx] <= reg_data[RV-1:RV-PPW];
            d_wr[ptr_idx]    <= reg_data[ENT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_vp  <= '0;
         ptr_ctx <= '0;
         ptr_ins <= 1'b0;
         ptr_sup <= 1'b0;
         f_pend  <= 1'b0;
         f_ovf   <= 1'b0;
         f_ins   <= 1'b0;
         f_sup   <= 1'b0;
         f_type  <= 1'b0;
         f_vpage <= '0;
         f_ctx   <= '0;
      end else if (mmu_fault) begin
         if (!f_pend) begin
            f_pend  <= 1'b1;
            f_vpage <= i_miss ? pc_vp : ad_vp;
            f_ctx   <= ctx;
            f_ins   <= i_miss;
            f_sup   <= supmode;
            f_type  <= (i_miss | d_miss) ? FT_MISS : FT_PROT;
         end else begin
            f_ovf <= 1'b1;
         end
      end else if (ctrl_we) begin
         ptr_vp  <= reg_data[RV-1:RV-VW];
         ptr_ctx <= reg_data[RV-VW-1:RV-VW-CW];
         ptr_ins <= reg_data[CTRL_INS];
         ptr_sup <= reg_data[CTRL_SUP];
         if (reg_data[CTRL_CLR]) begin
            f_pend <= 1'b0;
            f_ovf  <= 1'b0;
         end
      end else if (ent_we) begin
         ptr_vp <= ptr_vp + VP_ONE;
      end
   end

   assign reg_read = {f_vpage, f_ctx, {(RV-VW-CW-5){1'b0}}, f_ovf, f_pend, f_ins, f_sup, f_type};

   assign unused_bits = ^{reg_data[RV-VW-CW-1:4], reg_data[0]};

endmodule

// File: tb/tb_mmu_ctx.sv
// Directed bench for mmu_ctx: translation vector table plus fault, wrap,
// sweep and reset-abort sequences.
module tb_mmu_ctx;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        mmu_enable = 1'b0, supmode = 1'b0;
   logic [1:0]  ctx = '0;
   logic        is_pc = 1'b0, is_read = 1'b0, is_write = 1'b0;
   logic [15:1] pcv = '0, addrv = '0;
   logic [15:1] pcp, addrp;
   logic        mmu_miss_fault, mmu_prot_fault;
   logic        mmu_fault = 1'b0, inv_req = 1'b0, inv_all_ctx = 1'b0;
   logic [3:0]  inv_mask = '0;
   logic        inv_busy;
   logic        reg_write = 1'b0, reg_sel = 1'b0;
   logic [15:0] reg_data = '0;
   logic [15:0] reg_read;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic F0 = 1'b0;
   localparam logic T1 = 1'b1;

   typedef struct {
      logic        en;
      logic [1:0]  c;
      logic        sup, pc, rd, wr;
      logic [15:0] pa, da, ep, ea;
      logic        em, epr, cp, ca;
   } vec_t;

   mmu_ctx dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mmu_enable     (mmu_enable),
      .supmode        (supmode),
      .ctx            (ctx),
      .is_pc          (is_pc),
      .is_read        (is_read),
      .is_write       (is_write),
      .pcv            (pcv),
      .addrv          (addrv),
      .pcp            (pcp),
      .addrp          (addrp),
      .mmu_miss_fault (mmu_miss_fault),
      .mmu_prot_fault (mmu_prot_fault),
      .mmu_fault      (mmu_fault),
      .inv_req        (inv_req),
      .inv_mask       (inv_mask),
      .inv_all_ctx    (inv_all_ctx),
      .inv_busy       (inv_busy),
      .reg_write      (reg_write),
      .reg_sel        (reg_sel),
      .reg_data       (reg_data),
      .reg_read       (reg_read)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input logic [15:0] exp);
      chk(nm, {17'b0, addrp}, {17'b0, exp[15:1]});
   endtask

   task automatic chk_p(input string nm, input logic [15:0] exp);
      chk(nm, {17'b0, pcp}, {17'b0, exp[15:1]});
   endtask

   task automatic acc(input logic en, input logic [1:0] c, input logic s, input logic pc,
                      input logic rd, input logic wr, input logic [15:0] p, input logic [15:0] a);
      mmu_enable = en; ctx = c; supmode = s;
      is_pc = pc; is_read = rd; is_write = wr;
      pcv = p[15:1]; addrv = a[15:1];
      #1;
   endtask

   task automatic idle_acc();
      is_pc = 1'b0; is_read = 1'b0; is_write = 1'b0;
   endtask

   task automatic reg_wr(input logic sel, input logic [15:0] d);
      reg_write = 1'b1; reg_sel = sel; reg_data = d;
      tick();
      reg_write = 1'b0;
   endtask

   function automatic logic [15:0] ptr_d(input logic [2:0] vp, input logic [1:0] c,
                                         input logic ins, input logic sup, input logic clr);
      return {vp, c, 7'b0, ins, sup, clr, 1'b0};
   endfunction

   function automatic logic [15:0] ent_d(input logic [2:0] pp, input logic w, input logic v);
      return {pp, 10'b0, w, v, 1'b0};
   endfunction

   initial begin
      vec_t vt [10];
      int   cnt;

      vt[0] = '{T1, 2'd1, F0, F0, T1, F0, 16'h0000, 16'h4123, 16'h0000, 16'hA123, F0, F0, F0, T1};
      vt[1] = '{T1, 2'd0, F0, F0, T1, F0, 16'h0000, 16'h4123, 16'h0000, 16'h0000, T1, F0, F0, F0};
      vt[2] = '{T1, 2'd1, F0, F0, F0, T1, 16'h0000, 16'h4123, 16'h0000, 16'hA123, F0, F0, F0, T1};
      vt[3] = '{T1, 2'd1, F0, F0, F0, T1, 16'h0000, 16'h6010, 16'h0000, 16'hC010, F0, T1, F0, T1};
      vt[4] = '{T1, 2'd1, F0, F0, T1, F0, 16'h0000, 16'h6010, 16'h0000, 16'hC010, F0, F0, F0, T1};
      vt[5] = '{T1, 2'd1, F0, T1, F0, F0, 16'h4456, 16'h0000, 16'h6456, 16'h0000, F0, F0, T1, F0};
      vt[6] = '{T1, 2'd1, T1, F0, T1, F0, 16'h0000, 16'h4123, 16'h0000, 16'hE123, F0, F0, F0, T1};
      vt[7] = '{T1, 2'd1, T1, T1, F0, F0, 16'h4456, 16'h0000, 16'h0000, 16'h0000, T1, F0, F0, F0};
      vt[8] = '{T1, 2'd1, F0, T1, F0, F0, 16'h6000, 16'h0000, 16'h0000, 16'h0000, T1, F0, F0, F0};
      vt[9] = '{F0, 2'd0, F0, F0, F0, T1, 16'h1234, 16'h4123, 16'h1234, 16'h4123, F0, F0, T1, T1};

      // Reset state, identity translation with the MMU disabled
      tick(); tick();
      acc(F0, 2'd0, F0, T1, T1, F0, 16'h1234, 16'h4122);
      chk("rst_busy", inv_busy, 0);
      chk("rst_reg_read", reg_read, 0);
      chk("rst_miss", mmu_miss_fault, 0);
      chk_p("rst_pcp_identity", 16'h1234);
      chk_a("rst_addrp_identity", 16'h4122);
      reset_n = 1'b1;
      tick();

      // First miss and its capture
      acc(T1, 2'd0, F0, F0, T1, F0, 16'h0000, 16'h4000);
      chk("miss_on_empty", mmu_miss_fault, 1);
      chk("no_prot_on_empty", mmu_prot_fault, 0);
      mmu_fault = 1'b1; tick(); mmu_fault = 1'b0;
      chk("fault_capture_miss", reg_read, 16'h4009);
      idle_acc();
      reg_wr(1'b0, ptr_d(3'd2, 2'd1, F0, F0, T1));
      chk("ctrl_clear_pending", reg_read, 16'h4001);

      // Program entries: D ctx1 user vp2/vp3, I ctx1 user vp2, D ctx1 sup vp2
      reg_wr(1'b1, ent_d(3'd5, T1, T1));
      reg_wr(1'b1, ent_d(3'd6, F0, T1));
      reg_wr(1'b0, ptr_d(3'd2, 2'd1, T1, F0, F0));
      reg_wr(1'b1, ent_d(3'd3, F0, T1));
      reg_wr(1'b0, ptr_d(3'd2, 2'd1, F0, T1, F0));
      reg_wr(1'b1, ent_d(3'd7, T1, T1));

      for (int i = 0; i < 10; i++) begin
         acc(vt[i].en, vt[i].c, vt[i].sup, vt[i].pc, vt[i].rd, vt[i].wr, vt[i].pa, vt[i].da);
         chk($sformatf("xlat%0d_miss", i), mmu_miss_fault, {31'b0, vt[i].em});
         chk($sformatf("xlat%0d_prot", i), mmu_prot_fault, {31'b0, vt[i].epr});
         if (vt[i].cp) chk_p($sformatf("xlat%0d_pcp", i), vt[i].ep);
         if (vt[i].ca) chk_a($sformatf("xlat%0d_addrp", i), vt[i].ea);
      end

      // Protection fault, then overflow with a coincident (dropped) ctrl write
      acc(T1, 2'd1, F0, F0, F0, T1, 16'h0000, 16'h6010);
      mmu_fault = 1'b1; tick(); mmu_fault = 1'b0;
      chk("fault_capture_prot", reg_read, 16'h6808);
      acc(T1, 2'd0, F0, F0, T1, F0, 16'h0000, 16'h4000);
      mmu_fault = 1'b1; reg_write = 1'b1; reg_sel = 1'b0; reg_data = ptr_d(3'd0, 2'd0, F0, F0, T1);
      tick();
      mmu_fault = 1'b0; reg_write = 1'b0;
      chk("fault_overflow_hold", reg_read, 16'h6818);
      idle_acc();
      reg_wr(1'b0, ptr_d(3'd7, 2'd2, F0, F0, T1));
      chk("ctrl_clear_both", reg_read, 16'h6800);

      // Pointer wrap: eight writes from vp7 into ctx2 user D
      for (int i = 0; i < 8; i++) reg_wr(1'b1, ent_d(3'(i), T1, T1));
      for (int v = 0; v < 8; v++) begin
         logic [15:0] a, e;
         a = {v[2:0], 13'h0ABC};
         e = {3'(v + 1), 13'h0ABC};
         acc(T1, 2'd2, F0, F0, T1, F0, 16'h0000, a);
         chk($sformatf("wrap_vp%0d_addrp", v), {17'b0, addrp}, {17'b0, e[15:1]});
         chk($sformatf("wrap_vp%0d_miss", v), mmu_miss_fault, 0);
      end
      idle_acc();
      reg_wr(1'b1, ent_d(3'd4, T1, T1));
      acc(T1, 2'd2, F0, F0, T1, F0, 16'h0000, 16'hE0BC);
      chk_a("wrap_ninth_vp7", 16'h80BC);
      acc(T1, 2'd2, F0, F0, T1, F0, 16'h0000, 16'h0ABC);
      chk_a("wrap_vp0_kept", 16'h2ABC);
      idle_acc();

      // Single-context sweep of ctx1 user D
      ctx = 2'd1; inv_mask = 4'b0001; inv_all_ctx = 1'b0; inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      cnt = 0;
      while (inv_busy && cnt < 100) begin cnt++; tick(); end
      chk("sweep_ctx_len", cnt, 8);
      acc(T1, 2'd1, F0, F0, T1, F0, 16'h0000, 16'h4123);
      chk("sweep_ud_vp2_miss", mmu_miss_fault, 1);
      acc(T1, 2'd1, F0, F0, T1, F0, 16'h0000, 16'h6010);
      chk("sweep_ud_vp3_miss", mmu_miss_fault, 1);
      acc(T1, 2'd1, F0, T1, F0, F0, 16'h4456, 16'h0000);
      chk("sweep_ui_hit", mmu_miss_fault, 0);
      chk_p("sweep_ui_pcp", 16'h6456);
      acc(T1, 2'd1, T1, F0, T1, F0, 16'h0000, 16'h4123);
      chk("sweep_sd_hit", mmu_miss_fault, 0);
      chk_a("sweep_sd_addrp", 16'hE123);
      acc(T1, 2'd2, F0, F0, T1, F0, 16'h0000, 16'h0ABC);
      chk("sweep_other_ctx_hit", mmu_miss_fault, 0);
      idle_acc();

      // All-context sweep with empty mask; busy-time requests and writes
      inv_mask = 4'b0000; inv_all_ctx = 1'b1; inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      cnt = 0;
      while (inv_busy && cnt < 200) begin
         cnt++;
         inv_req   = (cnt == 3);
         reg_write = (cnt == 4) || (cnt == 5);
         reg_sel   = (cnt == 5);
         reg_data  = (cnt == 4) ? ptr_d(3'd0, 2'd3, F0, F0, F0) : ent_d(3'd1, T1, T1);
         if (cnt == 6) begin
            acc(T1, 2'd0, F0, F0, T1, F0, 16'h0000, 16'h4000);
            chk("busy_masks_miss", mmu_miss_fault, 0);
            idle_acc();
         end
         tick();
      end
      inv_req = 1'b0; reg_write = 1'b0;
      chk("sweep_all_len", cnt, 32);
      acc(T1, 2'd3, F0, F0, T1, F0, 16'h0000, 16'h0ABC);
      chk("busy_entry_dropped", mmu_miss_fault, 1);
      acc(T1, 2'd2, F0, F0, T1, F0, 16'h0000, 16'hE0BC);
      chk("empty_mask_keeps", mmu_miss_fault, 0);
      chk_a("empty_mask_addrp", 16'h80BC);
      idle_acc();
      reg_wr(1'b1, ent_d(3'd1, T1, T1));
      acc(T1, 2'd3, F0, F0, T1, F0, 16'h0000, 16'h0ABC);
      chk("busy_ptr_accepted", mmu_miss_fault, 0);
      chk_a("busy_ptr_addrp", 16'h2ABC);
      idle_acc();

      // Reset during the third sweep cycle
      inv_mask = 4'b1111; inv_all_ctx = 1'b1; inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      tick(); tick();
      chk("abort_busy_before", inv_busy, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy_drops", inv_busy, 0);
      tick();
      reset_n = 1'b1;
      tick();
      acc(T1, 2'd2, F0, F0, T1, F0, 16'h0000, 16'hE0BC);
      chk("abort_d_ctx2_invalid", mmu_miss_fault, 1);
      acc(T1, 2'd1, F0, T1, F0, F0, 16'h4456, 16'h0000);
      chk("abort_i_ctx1_invalid", mmu_miss_fault, 1);
      acc(T1, 2'd1, T1, F0, T1, F0, 16'h0000, 16'h4123);
      chk("abort_sd_ctx1_invalid", mmu_miss_fault, 1);
      chk("abort_reg_read", reg_read, 0);
      idle_acc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
